// File: rtl/rgb_led_pwm_pkg.sv
// Shared constants, types and helpers for the RGB LED PWM dimmer.
package rgb_led_pwm_pkg;

  localparam int PWM_DUTY_WIDTH_DEFAULT = 8;
  localparam int PWM_PRESCALE_1KHZ_125M = 488;

  // Direction of the optional breathing ramp.
  typedef enum logic {
    RAMP_UP   = 1'b0,
    RAMP_DOWN = 1'b1
  } ramp_dir_t;

  // Width of the channel index on the config port; never narrower than one bit.
  function automatic int cfg_channel_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/rgb_led_pwm_if.sv
// Config write port of the LED dimmer: valid/ready duty writes plus a sticky
// error flag for writes aimed at a channel that does not exist.
interface rgb_led_pwm_if
  import rgb_led_pwm_pkg::*;
#(
  parameter int CHANNELS   = 16,
  parameter int DUTY_WIDTH = PWM_DUTY_WIDTH_DEFAULT
) ();

  localparam int CH_W = cfg_channel_width(CHANNELS);

  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [CH_W-1:0]       cfg_channel;
  logic [DUTY_WIDTH-1:0] cfg_duty;
  logic                  cfg_err;

  modport master (
    output cfg_valid,
    output cfg_channel,
    output cfg_duty,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_channel,
    input  cfg_duty,
    output cfg_ready,
    output cfg_err
  );

endinterface

// File: rtl/rgb_led_pwm_pwm_timebase.sv
// PWM timebase: prescaler, period counter, tick/boundary strobes and a
// registered period_start pulse. Usable by any dimmed output.
module pwm_timebase
  import rgb_led_pwm_pkg::*;
#(
  parameter int DUTY_WIDTH = PWM_DUTY_WIDTH_DEFAULT,
  parameter int PRESCALE   = PWM_PRESCALE_1KHZ_125M
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [DUTY_WIDTH-1:0] pwm_cnt,
  output logic                  boundary,
  output logic                  period_start
);

  // PRESCALE=1 degenerates to a one-bit prescaler stuck at 0, so tick is constant 1.
  localparam int PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRESC_W-1:0]    PRESC_LAST = PRESC_W'(PRESCALE - 1);
  localparam logic [DUTY_WIDTH-1:0] CNT_LAST   = '1;

  logic [PRESC_W-1:0]    prescaler_reg;
  logic [DUTY_WIDTH-1:0] pwm_cnt_reg;
  logic                  period_start_reg;
  logic                  tick;

  assign tick         = (prescaler_reg == PRESC_LAST);
  assign boundary     = tick && (pwm_cnt_reg == CNT_LAST);
  assign pwm_cnt      = pwm_cnt_reg;
  assign period_start = period_start_reg;

  // Prescaler counts 0..PRESCALE-1 and wraps on tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_reg <= '0;
    end else if (tick) begin
      prescaler_reg <= '0;
    end else begin
      prescaler_reg <= prescaler_reg + 1'b1;
    end
  end

  // PWM counter advances once per tick and wraps naturally at 2^DUTY_WIDTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_reg <= '0;
    end else if (tick) begin
      pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
    end
  end

  // period_start is high exactly while pwm_cnt reads 0 right after a wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_start_reg <= 1'b0;
    end else begin
      period_start_reg <= boundary;
    end
  end

endmodule

// File: rtl/rgb_led_pwm.sv
// Per-channel PWM dimmer for board LEDs. Duty writes land in a shadow bank and
// are copied to the active bank only at period boundaries, so a period never
// mixes two duty values. Optional breathing ramp: RGB_LED_PWM_BREATHE_EN.
module rgb_led_pwm
  import rgb_led_pwm_pkg::*;
#(
  parameter int CHANNELS   = 16,
  parameter int DUTY_WIDTH = PWM_DUTY_WIDTH_DEFAULT,
  parameter int PRESCALE   = PWM_PRESCALE_1KHZ_125M,
  parameter int DUTY_RESET = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] led_in,
`ifdef RGB_LED_PWM_BREATHE_EN
  input  logic                breathe,
`endif
  rgb_led_pwm_if.slave        cfg,
  output logic [CHANNELS-1:0] led_out,
  output logic                period_start
);

  localparam int CH_W = cfg_channel_width(CHANNELS);
  localparam logic [31:0]           CHANNELS_U = 32'(CHANNELS);
  localparam logic [DUTY_WIDTH-1:0] DUTY_INIT  = DUTY_WIDTH'(DUTY_RESET);

  logic [DUTY_WIDTH-1:0] pwm_cnt;
  logic                  boundary;

  logic                  cfg_ready_reg;
  logic                  cfg_err_reg;
  logic                  cfg_fire;
  logic                  cfg_in_range;
  logic [CH_W-1:0]       cfg_channel;

  logic [DUTY_WIDTH-1:0] duty_shadow_reg [CHANNELS];
  logic [DUTY_WIDTH-1:0] duty_active_reg [CHANNELS];
  logic [DUTY_WIDTH-1:0] duty_eff [CHANNELS];
  logic [CHANNELS-1:0]   gate;
  logic [CHANNELS-1:0]   led_in_q_reg;
  logic [CHANNELS-1:0]   led_out_reg;

  pwm_timebase #(
    .DUTY_WIDTH (DUTY_WIDTH),
    .PRESCALE   (PRESCALE)
  ) u_timebase (
    .clk          (clk),
    .rst_n        (rst_n),
    .pwm_cnt      (pwm_cnt),
    .boundary     (boundary),
    .period_start (period_start)
  );

  assign cfg_channel   = cfg.cfg_channel;
  assign cfg_fire      = cfg.cfg_valid && cfg_ready_reg;
  assign cfg_in_range  = (32'(cfg_channel) < CHANNELS_U);
  assign cfg.cfg_ready = cfg_ready_reg;
  assign cfg.cfg_err   = cfg_err_reg;
  assign led_out       = led_out_reg;

  // Config port is always able to accept once out of reset; ready is a plain register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ready_reg <= 1'b0;
    end else begin
      cfg_ready_reg <= 1'b1;
    end
  end

  // Sticky flag for writes to a channel beyond CHANNELS-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err_reg <= 1'b0;
    end else if (cfg_fire && !cfg_in_range) begin
      cfg_err_reg <= 1'b1;
    end
  end

  // Shadow/active duty banks. A write and a boundary in the same cycle copy the
  // old shadow, so the new value waits one full period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        duty_shadow_reg[i] <= DUTY_INIT;
        duty_active_reg[i] <= DUTY_INIT;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (boundary) begin
          duty_active_reg[i] <= duty_shadow_reg[i];
        end
        if (cfg_fire && cfg_in_range && (cfg_channel == CH_W'(i))) begin
          duty_shadow_reg[i] <= cfg.cfg_duty;
        end
      end
    end
  end

`ifdef RGB_LED_PWM_BREATHE_EN
  localparam logic [DUTY_WIDTH-1:0] RAMP_MAX = '1;
  localparam int PROD_W = 2 * DUTY_WIDTH;

  ramp_dir_t             ramp_dir_reg, ramp_dir_next;
  logic [DUTY_WIDTH-1:0] ramp_reg, ramp_next;

  // Triangle ramp state: one step per period boundary, free-running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ramp_reg     <= '0;
      ramp_dir_reg <= RAMP_UP;
    end else begin
      ramp_reg     <= ramp_next;
      ramp_dir_reg <= ramp_dir_next;
    end
  end

  // Ramp next-state: reverse direction on reaching either end.
  always_comb begin
    ramp_next     = ramp_reg;
    ramp_dir_next = ramp_dir_reg;
    if (boundary) begin
      case (ramp_dir_reg)
        RAMP_UP: begin
          if (ramp_reg == RAMP_MAX) begin
            ramp_next     = ramp_reg - 1'b1;
            ramp_dir_next = RAMP_DOWN;
          end else begin
            ramp_next = ramp_reg + 1'b1;
          end
        end
        default: begin
          if (ramp_reg == '0) begin
            ramp_next     = ramp_reg + 1'b1;
            ramp_dir_next = RAMP_UP;
          end else begin
            ramp_next = ramp_reg - 1'b1;
          end
        end
      endcase
    end
  end
`endif

  genvar gi;
  for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
`ifdef RGB_LED_PWM_BREATHE_EN
    logic [PROD_W-1:0] scaled;
    assign scaled       = PROD_W'(duty_active_reg[gi]) * PROD_W'(ramp_reg);
    assign duty_eff[gi] = breathe ? DUTY_WIDTH'(scaled >> DUTY_WIDTH) : duty_active_reg[gi];
`else
    assign duty_eff[gi] = duty_active_reg[gi];
`endif
    assign gate[gi] = (pwm_cnt < duty_eff[gi]);
  end

  // Two-stage output path: register the request, then gate it with the PWM compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_in_q_reg <= '0;
      led_out_reg  <= '0;
    end else begin
      led_in_q_reg <= led_in;
      led_out_reg  <= led_in_q_reg & gate;
    end
  end

endmodule

// File: tb/tb_rgb_led_pwm.sv
// Self-checking bench for rgb_led_pwm (PRESCALE=2, DUTY_WIDTH=4, CHANNELS=4,
// DUTY_RESET=4) plus a 5-channel instance for out-of-range config writes.
// The breathing scenario runs only when RGB_LED_PWM_BREATHE_EN is defined.
module tb_rgb_led_pwm;

  localparam int P    = 2;
  localparam int W    = 4;
  localparam int CH   = 4;
  localparam int DR   = 4;
  localparam int CH5  = 5;
  localparam int CHW  = 2;
  localparam int CHW5 = 3;
  localparam int NT   = 1 << W;
  localparam int MAXD = NT - 1;
  localparam int PER  = NT * P;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [CH-1:0]  led_in = '0;
  logic [CH-1:0]  led_out;
  logic           period_start;
  logic [CH5-1:0] led_in5 = '1;
  logic [CH5-1:0] led_out5;
  logic           period_start5;
  logic           breathe = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int       m_c;
  int       m_bnd;
  int       m_shadow [CH];
  int       m_active [CH];
  logic [CH-1:0] m_lq;
  logic     m_err;
  logic     m5_err;
  logic     ps_seen;
  int       hi  [CH];
  int       hi5 [CH5];
  int       p_win;

  always #5 clk = ~clk;

  rgb_led_pwm_if #(.CHANNELS(CH),  .DUTY_WIDTH(W)) cfg4 ();
  rgb_led_pwm_if #(.CHANNELS(CH5), .DUTY_WIDTH(W)) cfg5 ();

  rgb_led_pwm #(.CHANNELS(CH), .DUTY_WIDTH(W), .PRESCALE(P), .DUTY_RESET(DR)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .led_in       (led_in),
`ifdef RGB_LED_PWM_BREATHE_EN
    .breathe      (breathe),
`endif
    .cfg          (cfg4),
    .led_out      (led_out),
    .period_start (period_start)
  );

  rgb_led_pwm #(.CHANNELS(CH5), .DUTY_WIDTH(W), .PRESCALE(P), .DUTY_RESET(DR)) dut5 (
    .clk          (clk),
    .rst_n        (rst_n),
    .led_in       (led_in5),
`ifdef RGB_LED_PWM_BREATHE_EN
    .breathe      (1'b0),
`endif
    .cfg          (cfg5),
    .led_out      (led_out5),
    .period_start (period_start5)
  );

  function automatic int tri_ramp(input int p);
    int m;
    m = p % (2 * MAXD);
    return (m <= MAXD) ? m : (2 * MAXD - m);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_hi(input string tag, input int e0, input int e1, input int e2, input int e3);
    int e [CH];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int i = 0; i < CH; i++) chk($sformatf("%s_hi_ch%0d", tag, i), hi[i], e[i]);
  endtask

  task automatic model_reset();
    m_c = 0;
    m_bnd = 0;
    for (int i = 0; i < CH; i++) begin
      m_shadow[i] = DR;
      m_active[i] = DR;
    end
    m_lq = '0;
    m_err = 1'b0;
    m5_err = 1'b0;
    ps_seen = 1'b0;
  endtask

  // One clock: predict outputs from the period arithmetic and duty banks, then compare.
  task automatic step();
    logic [CH-1:0] exp_led;
    int cnt, rmp, eff;
    logic ready_prev, bnd;
    @(posedge clk);
    cnt = (m_c / P) % NT;
    rmp = tri_ramp(m_bnd);
    for (int i = 0; i < CH; i++) begin
      eff = breathe ? ((m_active[i] * rmp) >> W) : m_active[i];
      exp_led[i] = m_lq[i] && (cnt < eff);
    end
    ready_prev = (m_c >= 1);
    m_c++;
    bnd = ((m_c % PER) == 0);
    if (bnd) begin
      for (int i = 0; i < CH; i++) m_active[i] = m_shadow[i];
      m_bnd++;
    end
    if (cfg4.cfg_valid && ready_prev) begin
      if (int'(cfg4.cfg_channel) < CH) m_shadow[int'(cfg4.cfg_channel)] = int'(cfg4.cfg_duty);
      else m_err = 1'b1;
    end
    if (cfg5.cfg_valid && ready_prev && (int'(cfg5.cfg_channel) >= CH5)) m5_err = 1'b1;
    m_lq = led_in;
    #1;
    chk("led_out", 32'(led_out), 32'(exp_led));
    chk("period_start", 32'(period_start), 32'(bnd));
    chk("period_start5", 32'(period_start5), 32'(bnd));
    chk("cfg_ready", 32'(cfg4.cfg_ready), 32'd1);
    chk("cfg_err", 32'(cfg4.cfg_err), 32'(m_err));
    chk("cfg_err5", 32'(cfg5.cfg_err), 32'(m5_err));
    for (int i = 0; i < CH; i++) if (led_out[i]) hi[i]++;
    for (int i = 0; i < CH5; i++) if (led_out5[i]) hi5[i]++;
    ps_seen = period_start;
  endtask

  task automatic wait_ps();
    int n;
    n = 0;
    while (!ps_seen && n < 2 * PER) begin
      step();
      n++;
    end
    chk("period_start_timeout", 32'(ps_seen), 32'd1);
  endtask

  // Measure one full period of led_out right after period_start, optionally
  // issuing a write at offset wr_at (and a second write the cycle after).
  task automatic run_period(input int wr_at, input int ch_a, input int d_a,
                            input int ch_b, input int d_b);
    wait_ps();
    p_win = m_bnd;
    for (int i = 0; i < CH; i++) hi[i] = 0;
    for (int i = 0; i < CH5; i++) hi5[i] = 0;
    for (int k = 0; k < PER; k++) begin
      if (k == wr_at) begin
        cfg4.cfg_valid = 1'b1;
        cfg4.cfg_channel = CHW'(ch_a);
        cfg4.cfg_duty = W'(d_a);
      end else if (k == wr_at + 1) begin
        if (ch_b >= 0) begin
          cfg4.cfg_channel = CHW'(ch_b);
          cfg4.cfg_duty = W'(d_b);
        end else begin
          cfg4.cfg_valid = 1'b0;
        end
      end else if (k == wr_at + 2) begin
        cfg4.cfg_valid = 1'b0;
      end
      step();
    end
    cfg4.cfg_valid = 1'b0;
  endtask

  // Assert reset between edges, check asynchronous clearing, release on a falling edge.
  task automatic do_reset();
    rst_n = 1'b0;
    cfg4.cfg_valid = 1'b0;
    cfg5.cfg_valid = 1'b0;
    #1;
    chk("rst_led_out", 32'(led_out), 32'd0);
    chk("rst_period_start", 32'(period_start), 32'd0);
    chk("rst_cfg_ready", 32'(cfg4.cfg_ready), 32'd0);
    chk("rst_cfg_err", 32'(cfg4.cfg_err), 32'd0);
    chk("rst_cfg_err5", 32'(cfg5.cfg_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    chk("ready_at_release", 32'(cfg4.cfg_ready), 32'd0);
  endtask

  initial begin
    cfg4.cfg_valid = 1'b0;
    cfg4.cfg_channel = '0;
    cfg4.cfg_duty = '0;
    cfg5.cfg_valid = 1'b0;
    cfg5.cfg_channel = '0;
    cfg5.cfg_duty = '0;
    model_reset();
    #2;

    // Reset duty 4 on every channel
    led_in = 4'hF;
    do_reset();
    step();
    chk("s1_ready_after_release", 32'(cfg4.cfg_ready), 32'd1);
    run_period(-1, 0, 0, -1, 0);
    chk_hi("s1", 8, 8, 8, 8);
    for (int i = 0; i < CH5; i++) chk($sformatf("s1_hi5_ch%0d", i), hi5[i], 8);

    // Mid-period writes wait for the next period
    run_period(5, 2, 0, 3, 15);
    chk_hi("s2_same", 8, 8, 8, 8);
    run_period(-1, 0, 0, -1, 0);
    chk_hi("s2_next", 8, 8, 0, 30);

    // Write in the boundary cycle lands one period later
    run_period(31, 1, 8, -1, 0);
    chk_hi("s3_n", 8, 8, 0, 30);
    run_period(-1, 0, 0, -1, 0);
    chk_hi("s3_n1", 8, 8, 0, 30);
    run_period(-1, 0, 0, -1, 0);
    chk_hi("s3_n2", 8, 16, 0, 30);

    // Out-of-range channel on the 5-channel instance
    cfg5.cfg_valid = 1'b1;
    cfg5.cfg_channel = CHW5'(5);
    cfg5.cfg_duty = W'(15);
    step();
    cfg5.cfg_valid = 1'b0;
    chk("s4_err_set", 32'(cfg5.cfg_err), 32'd1);
    cfg5.cfg_valid = 1'b1;
    cfg5.cfg_channel = CHW5'(7);
    cfg5.cfg_duty = W'(0);
    step();
    cfg5.cfg_valid = 1'b0;
    run_period(-1, 0, 0, -1, 0);
    run_period(-1, 0, 0, -1, 0);
    chk("s4_err_sticky", 32'(cfg5.cfg_err), 32'd1);
    for (int i = 0; i < CH5; i++) chk($sformatf("s4_hi5_ch%0d", i), hi5[i], 8);
    do_reset();

    // Two-cycle latency and asynchronous reset
    run_period(3, 0, 15, -1, 0);
    led_in = 4'hE;
    run_period(-1, 0, 0, -1, 0);
    run_period(-1, 0, 0, -1, 0);
    chk("s5_off_hi_ch0", hi[0], 0);
    chk("s5_on_hi_ch1", hi[1], 8);
    wait_ps();
    step();
    step();
    step();
    led_in = 4'hF;
    step();
    chk("s5_lat1", 32'(led_out[0]), 32'd0);
    step();
    chk("s5_lat2", 32'(led_out[0]), 32'd1);
    for (int k = 0; k < 4; k++) step();
    chk("s5_on_before_rst", 32'(led_out[0]), 32'd1);
    #2;
    do_reset();

    // Randomized traffic against the model
    for (int n = 0; n < 640; n++) begin
      led_in = CH'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        cfg4.cfg_valid = 1'b1;
        cfg4.cfg_channel = CHW'($urandom);
        cfg4.cfg_duty = W'($urandom);
      end else begin
        cfg4.cfg_valid = 1'b0;
      end
      step();
    end
    cfg4.cfg_valid = 1'b0;

`ifdef RGB_LED_PWM_BREATHE_EN
    // Breathing ramp scales duty 15 once per period
    led_in = 4'hF;
    do_reset();
    breathe = 1'b1;
    step();
    for (int i = 0; i < CH; i++) begin
      cfg4.cfg_valid = 1'b1;
      cfg4.cfg_channel = CHW'(i);
      cfg4.cfg_duty = W'(15);
      step();
    end
    cfg4.cfg_valid = 1'b0;
    for (int n = 0; n < 34; n++) begin
      run_period(-1, 0, 0, -1, 0);
      for (int i = 0; i < CH; i++)
        chk($sformatf("s6_p%0d_ch%0d", p_win, i), hi[i], 2 * ((MAXD * tri_ramp(p_win)) >> W));
    end
    breathe = 1'b0;
    run_period(-1, 0, 0, -1, 0);
    chk_hi("s6_off", 30, 30, 30, 30);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rgb_led_pwm.md
Name: rgb_led_pwm

Overview:
- Per-channel PWM dimmer between the GPIO LED outputs of the Ethernet example core and the board LED pins (12 RGB channels plus 4 single LEDs on Arty-class boards).
- Undimmed RGB LEDs are too bright to read, so each on/off request from the core is gated by a programmable duty cycle.
- Duty values are written over a valid/ready config port and take effect only at PWM period boundaries, so there are no glitches.

Parameters:
- CHANNELS, 16, number of LED channels.
- DUTY_WIDTH, 8, width of the PWM counter and duty registers; one period = 2^DUTY_WIDTH ticks.
- PRESCALE, 488, clk cycles per PWM tick (125 MHz / 488 / 256 ≈ 1 kHz); legal range 1 and up.
- DUTY_RESET, 32, duty loaded into every channel at reset.

Ports:
- clk  input  1  system clock, 125 MHz; all logic on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- led_in  input  CHANNELS  on/off request per channel from the core; already synchronous to clk.
- cfg_valid  input  1  config write request.
- cfg_ready  output  1  config write accepted when valid&ready.
- cfg_channel  input  $clog2(CHANNELS)  target channel.
- cfg_duty  input  DUTY_WIDTH  new duty value.
- cfg_err  output  1  sticky flag: a write targeted a channel >= CHANNELS.
- led_out  output  CHANNELS  PWM-gated LED drive.
- period_start  output  1  one-cycle pulse when the PWM counter wraps to 0.

Behaviour:
- Reset values:
  - Outputs: led_out=0, period_start=0, cfg_err=0, cfg_ready=0.
  - Internal: prescaler=0, pwm_cnt=0, duty_shadow[i]=duty_active[i]=DUTY_RESET, led_in_q=0.
- cfg_ready is 1 from the first cycle after reset release; it is a pure register and never depends combinationally on cfg_valid.
- Prescaler:
  - Counts 0..PRESCALE-1, then wraps.
  - tick=1 in the cycle where prescaler==PRESCALE-1.
  - With PRESCALE=1, tick is 1 every cycle.
- PWM counter: on tick, pwm_cnt increments modulo 2^DUTY_WIDTH.
- Period boundary (boundary = tick && pwm_cnt==2^DUTY_WIDTH-1):
  - duty_active[i] <= duty_shadow[i] for all channels.
  - period_start registered to 1 for exactly the cycle in which pwm_cnt reads 0.
- Config write (cfg_valid&&cfg_ready):
  - In-range channel: duty_shadow[cfg_channel] <= cfg_duty.
  - Out-of-range channel: no register changes; cfg_err <= 1 and stays set until reset.
- Write and boundary in the same cycle: the copy uses the old shadow. The new value reaches duty_active at the next boundary, one full period later.
- Output path:
  - led_in_q <= led_in.
  - led_out[i] <= led_in_q[i] && (pwm_cnt < duty_eff[i]), with duty_eff = duty_active unless the optional feature is on.
- Latency: led_in to led_out is 2 clk cycles.
- Duty range:
  - duty=0 means always off.
  - duty=2^DUTY_WIDTH-1 means on for 255/256 ticks; 100% is not reachable by design.
- Comparison is unsigned and DUTY_WIDTH bits wide.
- Reset mid-period: all state returns to reset values immediately; pending shadow writes are lost.

Optional Feature:
- Macro: RGB_LED_PWM_BREATHE_EN.
- Defined:
  - Adds port breathe (input 1).
  - A DUTY_WIDTH-bit triangle ramp steps +1/-1 once per period boundary. It rises 0 to max, then falls back to 0, reversing at both ends; reset value 0, rising.
  - While breathe=1: duty_eff[i] = (duty_active[i]*ramp) >> DUTY_WIDTH.
  - While breathe=0: duty_eff = duty_active, and the ramp keeps running.
- Undefined: no breathe port, no ramp logic; duty_eff = duty_active.

Decomposition:
- Shared package/header holds:
  - constants PWM_DUTY_WIDTH_DEFAULT=8 and PWM_PRESCALE_1KHZ_125M=488;
  - the function computing the cfg_channel width.
- One sub-module, pwm_timebase:
  - contains the prescaler, pwm_cnt, the tick and boundary strobes, and period_start;
  - is reusable by other dimmed outputs.
- Top handles the duty registers, config port, gating and the optional ramp.

Test Plan:
Bench parameters are PRESCALE=2, DUTY_WIDTH=4, CHANNELS=4, DUTY_RESET=4, except scenario 6.
1. Reset release, led_in=4'hF, no writes → each led_out high for 4 of every 16 ticks (8 of 32 clk), aligned to period_start; cfg_ready=1 one cycle after rst_n rises.
2. Write ch2 duty=0 and ch3 duty=15 mid-period → no change until next period_start; then ch2 constantly 0, ch3 high 30 of 32 clk.
3. Write ch1 duty=8 in the exact boundary cycle → period N+1 still shows duty 4, period N+2 shows high 16 of 32 clk.
4. Write cfg_channel=5 (out of range) → cfg_err=1 and stays set, all duties unchanged; rst_n low clears it.
5. Toggle led_in[0] 0→1 with duty=15 → led_out[0] rises exactly 2 clk later when pwm_cnt<15; rst_n asserted mid-period forces led_out=0 asynchronously.
6. With RGB_LED_PWM_BREATHE_EN defined, breathe=1, duty=15 → high ticks per period follow (15*ramp)>>4 as ramp goes 0,1,...,15,14,...; breathe=0 restores 15/16 immediately.
